// File: rtl/dport_ctrl.sv
// dport_ctrl: memory-mapped debug output port.
// Buffers bytes written to DATA in a FIFO and drains them over a
// ready/valid style handshake. Raises a sticky done flag once a done
// request has been made and every buffered byte has been delivered.
module dport_ctrl #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs,
  input  logic       we,
  input  logic [1:0] addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic [7:0] dport_out,
  output logic       dport_write,
  input  logic       dport_ready,
  output logic       done
);

  localparam int Depth = 1 << DEPTH_LOG2;
  localparam int CntW  = DEPTH_LOG2 + 1;
  localparam logic [CntW-1:0] FullCount = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [7:0]            mem [Depth];
  logic [DEPTH_LOG2-1:0] rdPtr_q, rdPtr_d;
  logic [DEPTH_LOG2-1:0] wrPtr_q, wrPtr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  doneReq_q, doneReq_d;
  logic                  done_q, done_d;
  logic [7:0]            dataOut_q, dataOut_d;

  logic       busWrite, busRead;
  logic       isFull, isEmpty;
  logic       pop, push, drop, statusWrite, doneWrite;
  logic [31:0] countWide;
  logic [3:0] countSat;
  logic [7:0] readData;

  assign busWrite    = cs & we;
  assign busRead     = cs & ~we;
  assign isFull      = (count_q == FullCount);
  assign isEmpty     = (count_q == '0);
  assign pop         = ~isEmpty & dport_ready;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign push        = busWrite & (addr == 2'd0) & (~isFull | pop);
  assign drop        = busWrite & (addr == 2'd0) & isFull & ~pop;
  assign statusWrite = busWrite & (addr == 2'd1);
  assign doneWrite   = busWrite & (addr == 2'd2);

  assign countWide = 32'(count_q);
  assign countSat  = (countWide > 32'd15) ? 4'hF : countWide[3:0];

  assign dport_write = ~isEmpty;
  assign dport_out   = mem[rdPtr_q];
  assign data_out    = dataOut_q;
  assign done        = done_q;

  // Register read mux, evaluated on the pre-edge state.
  always_comb begin
    readData = 8'h00;
    case (addr)
      2'd1:    readData = {isFull, isEmpty, overflow_q, doneReq_q, countSat};
      2'd2:    readData = {7'b0, done_q};
      default: readData = 8'h00;
    endcase
  end

  // Next-state for pointers, occupancy, flags and registered read data.
  always_comb begin
    rdPtr_d    = rdPtr_q;
    wrPtr_d    = wrPtr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    doneReq_d  = doneReq_q;
    dataOut_d  = 8'h00;

    if (pop)  rdPtr_d = rdPtr_q + DEPTH_LOG2'(1);
    if (push) wrPtr_d = wrPtr_q + DEPTH_LOG2'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    if (drop)
      overflow_d = 1'b1;
    else if (statusWrite && data_in[5])
      overflow_d = 1'b0;

    if (doneWrite) doneReq_d = 1'b1;

    // Done looks at the post-edge occupancy so the last pop counts.
    done_d = done_q | (doneReq_d & (count_d == '0));

    if (busRead) dataOut_d = readData;
  end

  // FIFO storage; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr_q] <= data_in;
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdPtr_q    <= '0;
      wrPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      doneReq_q  <= 1'b0;
      done_q     <= 1'b0;
      dataOut_q  <= 8'h00;
    end else begin
      rdPtr_q    <= rdPtr_d;
      wrPtr_q    <= wrPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      doneReq_q  <= doneReq_d;
      done_q     <= done_d;
      dataOut_q  <= dataOut_d;
    end
  end

endmodule

// File: tb/tb_dport_ctrl.sv
// tb_dport_ctrl: self-checking bench for dport_ctrl.
// A queue-based reference model predicts every output each cycle; directed
// sequences and a vector table add hand-computed expectations on top.
module tb_dport_ctrl;

  localparam int DepthLog2 = 4;
  localparam int Depth     = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs = 1'b0;
  logic       we = 1'b0;
  logic [1:0] addr = 2'd0;
  logic [7:0] dataIn = 8'h00;
  logic       dportReady = 1'b0;
  logic [7:0] dataOut;
  logic [7:0] dportOut;
  logic       dportWrite;
  logic       done;

  dport_ctrl #(.DEPTH_LOG2(DepthLog2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cs          (cs),
    .we          (we),
    .addr        (addr),
    .data_in     (dataIn),
    .data_out    (dataOut),
    .dport_out   (dportOut),
    .dport_write (dportWrite),
    .dport_ready (dportReady),
    .done        (done)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  typedef struct {
    logic       cs;
    logic       we;
    logic [1:0] addr;
    logic [7:0] data;
    logic       ready;
    logic       expWrite;
    logic [7:0] expOut;
    logic [7:0] expDataOut;
    logic       expDone;
  } vec_t;

  logic [7:0] mQ[$];
  logic [7:0] actualLog[$];
  logic [7:0] sent[$];
  bit         mOvf;
  bit         mDoneReq;
  bit         mDone;
  logic [7:0] mDataOut;
  int         nCompared = 0;
  int         nMismatched = 0;
  vec_t       vecs[6];

  task automatic compare(input string name, input logic [7:0] actual, input logic [7:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%02h expected 0x%02h", name, actual, expected);
    end
  endtask

  function automatic logic [7:0] modelStatus();
    int c = mQ.size();
    logic [3:0] sat = (c > 15) ? 4'hF : 4'(c);
    return {(c == Depth) ? 1'b1 : 1'b0, (c == 0) ? 1'b1 : 1'b0, mOvf, mDoneReq, sat};
  endfunction

  task automatic modelReset();
    mQ.delete();
    mOvf     = 0;
    mDoneReq = 0;
    mDone    = 0;
    mDataOut = 8'h00;
  endtask

  task automatic applyStimulus(input logic c, input logic w, input logic [1:0] a,
                               input logic [7:0] d, input logic r);
    cs = c;
    we = w;
    addr = a;
    dataIn = d;
    dportReady = r;
    #1;
  endtask

  task automatic checkOutput();
    compare("model.dport_write", dportWrite, (mQ.size() != 0));
    if (mQ.size() != 0) compare("model.dport_out", dportOut, mQ[0]);
    compare("model.done", done, mDone);
    compare("model.data_out", dataOut, mDataOut);
  endtask

  // Model a clock edge from the rules: pop first, then the bus access.
  task automatic advance();
    bit doPop;
    logic [7:0] rd;
    if (dportWrite && dportReady) actualLog.push_back(dportOut);
    doPop = (mQ.size() != 0) && dportReady;
    rd = 8'h00;
    if (cs && !we) begin
      case (addr)
        2'd1:    rd = modelStatus();
        2'd2:    rd = {7'b0, mDone};
        default: rd = 8'h00;
      endcase
    end
    if (doPop) void'(mQ.pop_front());
    if (cs && we) begin
      case (addr)
        2'd0: if (mQ.size() < Depth) mQ.push_back(dataIn); else mOvf = 1;
        2'd1: if (dataIn[5]) mOvf = 0;
        2'd2: mDoneReq = 1;
        default: ;
      endcase
    end
    if (mDoneReq && mQ.size() == 0) mDone = 1;
    mDataOut = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input logic c, input logic w, input logic [1:0] a,
                       input logic [7:0] d, input logic r);
    applyStimulus(c, w, a, d, r);
    checkOutput();
    advance();
  endtask

  task automatic writeReg(input logic [1:0] a, input logic [7:0] d, input logic r);
    cycle(1'b1, 1'b1, a, d, r);
  endtask

  task automatic idle(input logic r);
    cycle(1'b0, 1'b0, 2'd0, 8'h00, r);
  endtask

  task automatic readCheck(input logic [1:0] a, input logic [7:0] exp,
                           input string name, input logic r);
    cycle(1'b1, 1'b0, a, 8'h00, r);
    applyStimulus(1'b0, 1'b0, 2'd0, 8'h00, r);
    compare(name, dataOut, exp);
    checkOutput();
    advance();
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b1, 2'd0, 8'h48, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 2'd0, 8'h69, 1'b1, 1'b1, 8'h48, 8'h00, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 8'h69, 8'h00, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 2'd1, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h40, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0};

    modelReset();
    repeat (2) @(posedge clk);
    #1;
    compare("reset.dport_write", dportWrite, 1'b0);
    compare("reset.done", done, 1'b0);
    compare("reset.data_out", dataOut, 8'h00);
    rst_n = 1'b1;

    // Basic two-byte transfer and status readback.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].cs, vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].ready);
      compare($sformatf("vec%0d.write", i), dportWrite, vecs[i].expWrite);
      if (vecs[i].expWrite) compare($sformatf("vec%0d.out", i), dportOut, vecs[i].expOut);
      compare($sformatf("vec%0d.data_out", i), dataOut, vecs[i].expDataOut);
      compare($sformatf("vec%0d.done", i), done, vecs[i].expDone);
      checkOutput();
      advance();
    end

    // Overflow: 17 bytes into a 16-deep FIFO with the consumer stalled.
    for (int i = 0; i < 17; i++) writeReg(2'd0, 8'(i), 1'b0);
    readCheck(2'd1, 8'hAF, "ovf.status", 1'b0);
    actualLog.delete();
    repeat (17) idle(1'b1);
    compare("ovf.drainCount", 8'(actualLog.size()), 8'd16);
    for (int i = 0; i < 16 && i < actualLog.size(); i++)
      compare($sformatf("ovf.drain%0d", i), actualLog[i], 8'(i));
    writeReg(2'd1, 8'h20, 1'b1);
    readCheck(2'd1, 8'h40, "ovf.cleared", 1'b1);

    // Push into a full FIFO while a pop frees a slot.
    for (int i = 0; i < 16; i++) writeReg(2'd0, 8'(8'h30 + i), 1'b0);
    writeReg(2'd0, 8'hAA, 1'b1);
    readCheck(2'd1, 8'h8F, "fullpop.status", 1'b0);
    actualLog.delete();
    repeat (17) idle(1'b1);
    compare("fullpop.drainCount", 8'(actualLog.size()), 8'd16);
    if (actualLog.size() > 0) begin
      compare("fullpop.first", actualLog[0], 8'h31);
      compare("fullpop.last", actualLog[actualLog.size() - 1], 8'hAA);
    end

    // Done waits for the FIFO to drain, then stays set.
    for (int i = 0; i < 3; i++) writeReg(2'd0, 8'(8'hC0 + i), 1'b0);
    writeReg(2'd2, 8'h00, 1'b0);
    readCheck(2'd2, 8'h00, "done.pending", 1'b0);
    idle(1'b1);
    idle(1'b1);
    applyStimulus(1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
    compare("done.beforeLast", done, 1'b0);
    checkOutput();
    advance();
    applyStimulus(1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
    compare("done.afterLast", done, 1'b1);
    checkOutput();
    advance();
    writeReg(2'd0, 8'h55, 1'b1);
    writeReg(2'd1, 8'h20, 1'b1);
    readCheck(2'd2, 8'h01, "done.readback", 1'b1);
    compare("done.sticky", done, 1'b1);
    repeat (3) idle(1'b1);

    // Asynchronous reset in the middle of a cycle with data queued.
    for (int i = 0; i < 5; i++) writeReg(2'd0, 8'(8'hE0 + i), 1'b0);
    cycle(1'b1, 1'b0, 2'd1, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
    compare("rst.preStatus", dataOut, 8'h15);
    checkOutput();
    rst_n = 1'b0;
    #1;
    compare("rst.dport_write", dportWrite, 1'b0);
    compare("rst.done", done, 1'b0);
    compare("rst.data_out", dataOut, 8'h00);
    #1;
    rst_n = 1'b1;
    modelReset();
    advance();
    readCheck(2'd1, 8'h40, "rst.postStatus", 1'b0);

    // Streaming: a write every other cycle, ready toggling every cycle.
    actualLog.delete();
    sent.delete();
    for (int i = 0; i < 200; i++) begin
      if (i % 2 == 0) begin
        logic [7:0] b;
        b = 8'($urandom);
        sent.push_back(b);
        writeReg(2'd0, b, 1'b0);
      end else begin
        idle(1'b1);
      end
    end
    repeat (4) idle(1'b1);
    compare("stream.count", 8'(actualLog.size()), 8'd100);
    for (int i = 0; i < sent.size() && i < actualLog.size(); i++)
      compare($sformatf("stream.byte%0d", i), actualLog[i], sent[i]);
    readCheck(2'd1, 8'h40, "stream.status", 1'b1);

    // Random bus traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
            2'($urandom), 8'($urandom), 1'($urandom_range(0, 9) < 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
